node_input_buffer: RTL and testbench

Per-port receive FIFO that terminates one inter-node link on the consuming side of a `node_port`. It drives the link's `ack` backpressure and absorbs up to `DEPTH` flits. It then re-presents them, in order, on a second `node_port` toward the router's switching logic. Every router input port instantiates one.

---
 rtl/noc_pkg.sv | 5 +
 rtl/node_port.sv | 10 +
 rtl/flit_fifo_mem.sv | 22 ++
 rtl/node_input_buffer.sv | 78 +++++++
 tb/tb_node_input_buffer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: the opaque flit carried on every inter-node link.
package noc_pkg;
  localparam int FLIT_W = 8;
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/node_port.sv
// Inter-node link bundle: flit/enable travel downstream, ack travels back upstream.
interface node_port;
  import noc_pkg::*;
  flit_t flit;
  logic  enable;
  logic  ack;

  modport down(input flit, input enable, output ack);
  modport up(output flit, output enable, input ack);
endinterface

// File: rtl/flit_fifo_mem.sv
// DEPTH x flit_t storage with one write port and one asynchronous read port; contents never reset.
module flit_fifo_mem
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  flit_t            wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output flit_t            rd_data
);
  flit_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/node_input_buffer.sv
// Per-port receive FIFO terminating one inter-node link and re-presenting flits toward the router.
// Optional cut-through when empty: define NODE_INPUT_BUFFER_BYPASS_EN.
module node_input_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  node_port.down           link_in,
  node_port.up             link_out,
  output logic [CNT_W-1:0] occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("node_input_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  flit_t            rd_data;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (occupancy == CNT_W'(DEPTH));
  assign empty = (occupancy == '0);

  // ack depends on the counter only, so a pop at full cannot open the link this cycle
  assign link_in.ack = !full;

`ifdef NODE_INPUT_BUFFER_BYPASS_EN
  logic bypass_xfer;

  assign link_out.enable = empty ? link_in.enable : 1'b1;
  assign link_out.flit   = empty ? link_in.flit   : rd_data;
  assign bypass_xfer     = empty && link_in.enable && link_out.ack;
  assign push            = link_in.enable && link_in.ack && !bypass_xfer;
  assign pop             = !empty && link_out.ack;
`else
  assign link_out.enable = !empty;
  assign link_out.flit   = rd_data;
  assign push            = link_in.enable && link_in.ack;
  assign pop             = link_out.enable && link_out.ack;
`endif

  flit_fifo_mem #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr),
    .wr_data(link_in.flit),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: tb/tb_node_input_buffer.sv
// Scoreboard bench for node_input_buffer (DEPTH = 4); bypass checks only when NODE_INPUT_BUFFER_BYPASS_EN is set.
module tb_node_input_buffer;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] occupancy;
  int         total = 0;
  int         bad = 0;
  flit_t      exp_q[$];

  node_port in_if ();
  node_port out_if ();

  node_input_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .link_in  (in_if),
    .link_out (out_if),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Advance one clock; record the accepted input flit and report any output transfer.
  task automatic step(output bit pushed, output bit popped, output flit_t got);
    #1;
    pushed = in_if.enable && in_if.ack;
    popped = out_if.enable && out_if.ack;
    got    = out_if.flit;
    if (pushed) exp_q.push_back(in_if.flit);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (occupancy !== 3'd0 || in_if.ack !== 1'b1 || out_if.enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_state occ=%0d ack=%b en=%b required occ=0 ack=1 en=0",
               occupancy, in_if.ack, out_if.enable);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit pu, po;
    flit_t got, exp;
    out_if.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_if.enable = 1'b1;
      in_if.flit   = flit_t'(8'h40 + i);
      step(pu, po, got);
    end
    in_if.flit = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (occupancy !== 3'd0 || in_if.ack !== 1'b1 || out_if.enable !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset occ=%0d ack=%b en=%b required occ=0 ack=1 en=0",
               occupancy, in_if.ack, out_if.enable);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_if.flit = 8'hA5;
    step(pu, po, got);
    in_if.enable = 1'b0;
    out_if.ack   = 1'b1;
    step(pu, po, got);
    total++;
    if (!po || exp_q.size() == 0) begin
      bad++;
      $display("FAIL after_reset_pop popped=%b required popped=1", po);
    end else begin
      exp = exp_q.pop_front();
      total++;
      if (got !== exp || exp !== 8'hA5) begin
        bad++;
        $display("FAIL after_reset_flit got=%h required=a5", got);
      end
    end
    out_if.ack = 1'b0;
  endtask

  task automatic test_fill();
    bit pu, po;
    flit_t got;
    out_if.ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_if.enable = 1'b1;
      in_if.flit   = flit_t'(i);
      step(pu, po, got);
      total++;
      if (occupancy !== 3'(i) || in_if.ack !== (i != 4)) begin
        bad++;
        $display("FAIL fill_%0d occ=%0d ack=%b required occ=%0d ack=%b",
                 i, occupancy, in_if.ack, i, (i != 4));
      end
    end
    in_if.flit = 8'h05;
    for (int i = 0; i < 2; i++) begin
      step(pu, po, got);
      total++;
      if (pu || occupancy !== 3'd4) begin
        bad++;
        $display("FAIL fill_hold accepted=%b occ=%0d required accepted=0 occ=4", pu, occupancy);
      end
    end
    in_if.enable = 1'b0;
  endtask

  task automatic test_drain();
    bit pu, po;
    flit_t got, exp;
    out_if.ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(pu, po, got);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      total++;
      if (!po || got !== exp || exp !== flit_t'(i)) begin
        bad++;
        $display("FAIL drain_%0d popped=%b got=%h required popped=1 flit=%h", i, po, got, i);
      end
      if (i == 1) begin
        total++;
        if (in_if.ack !== 1'b1) begin
          bad++;
          $display("FAIL drain_ack ack=%b required=1", in_if.ack);
        end
      end
    end
    total++;
    if (out_if.enable !== 1'b0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty en=%b occ=%0d required en=0 occ=0", out_if.enable, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    bit pu, po;
    flit_t got, exp;
    int exp_occ;
`ifdef NODE_INPUT_BUFFER_BYPASS_EN
    exp_occ = 0;
`else
    exp_occ = 1;
`endif
    out_if.ack = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_if.enable = (i < 12);
      in_if.flit   = flit_t'(8'h10 + i);
      step(pu, po, got);
      if (po) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL b2b_order idx=%0d got=%h required=%h", i, got, exp);
        end
      end
      if (i > 0 && i < 12) begin
        total++;
        if (occupancy !== 3'(exp_occ)) begin
          bad++;
          $display("FAIL b2b_occ idx=%0d occ=%0d required=%0d", i, occupancy, exp_occ);
        end
      end
    end
    in_if.enable = 1'b0;
    total++;
    if (exp_q.size() != 0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL b2b_leftover queue=%0d occ=%0d required 0 0", exp_q.size(), occupancy);
    end
  endtask

  task automatic test_random_gaps();
    bit pu, po;
    flit_t got, exp;
    int sent = 0;
    int cyc = 0;
    in_if.enable = 1'b1;
    in_if.flit   = 8'h80;
    while ((sent < 20 || exp_q.size() != 0) && cyc < 200) begin
      out_if.ack = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      step(pu, po, got);
      cyc++;
      if (pu) begin
        sent++;
        in_if.flit   = flit_t'(8'h80 + sent);
        in_if.enable = (sent < 20);
      end
      if (po) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL gaps_order got=%h required=%h", got, exp);
        end
      end
    end
    in_if.enable = 1'b0;
    total++;
    if (sent != 20 || exp_q.size() != 0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL gaps_done sent=%0d queue=%0d occ=%0d required 20 0 0",
               sent, exp_q.size(), occupancy);
    end
  endtask

  task automatic test_stall();
    bit pu, po;
    flit_t got, exp;
    out_if.ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_if.enable = 1'b1;
      in_if.flit   = (i == 0) ? 8'h5A : 8'h6B;
      step(pu, po, got);
    end
    in_if.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(pu, po, got);
      total++;
      if (out_if.enable !== 1'b1 || got !== 8'h5A) begin
        bad++;
        $display("FAIL stall_%0d en=%b flit=%h required en=1 flit=5a", i, out_if.enable, got);
      end
    end
    out_if.ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(pu, po, got);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      total++;
      if (!po || got !== exp) begin
        bad++;
        $display("FAIL stall_drain popped=%b got=%h required=%h", po, got, exp);
      end
    end
  endtask

`ifdef NODE_INPUT_BUFFER_BYPASS_EN
  task automatic test_bypass();
    bit pu, po;
    flit_t got, exp;
    out_if.ack   = 1'b1;
    in_if.enable = 1'b1;
    in_if.flit   = 8'h3C;
    step(pu, po, got);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    total++;
    if (!po || got !== 8'h3C || exp !== 8'h3C || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL bypass_cut popped=%b flit=%h occ=%0d required 1 3c 0", po, got, occupancy);
    end
    out_if.ack = 1'b0;
    step(pu, po, got);
    in_if.enable = 1'b0;
    total++;
    if (occupancy !== 3'd1) begin
      bad++;
      $display("FAIL bypass_stalled occ=%0d required=1", occupancy);
    end
    out_if.ack = 1'b1;
    step(pu, po, got);
    exp_q.delete();
  endtask
`endif

  initial begin
    in_if.enable = 1'b0;
    in_if.flit   = '0;
    out_if.ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset_mid_stream();
    test_fill();
    test_drain();
    test_back_to_back();
    test_random_gaps();
    test_stall();
`ifdef NODE_INPUT_BUFFER_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
